// File: rtl/wired_issue_scoreboard.sv
// In-order 2-wide issue gate: holds one fetch packet, tracks register-busy bits, releases hazard-free slots.
// Optional stall statistics counter enabled by defining WIRED_SB_STAT_EN.
module wired_issue_scoreboard #(
    parameter int NUM_WB  = 2,
    parameter int REG_NUM = 32,
    parameter int SLOT_W  = 32    // slot layout: [4:0] r_reg[0], [9:5] r_reg[1], [14:10] w_reg, rest opaque
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  pkg_valid_i,
    output logic                  pkg_ready_o,
    input  logic [1:0]            pkg_mask_i,
    input  logic [2*SLOT_W-1:0]   pkg_i,
    input  logic [NUM_WB-1:0]     wb_valid_i,
    input  logic [NUM_WB*5-1:0]   wb_reg_i,
    output logic                  is_valid_o,
    input  logic                  is_ready_i,
    output logic [1:0]            is_mask_o,
    output logic [2*SLOT_W-1:0]   is_pkg_o,
    output logic [31:0]           perf_stall_o
);

    logic                  h_valid_reg, h_valid_next;
    logic [1:0]            h_mask_reg, h_mask_next;
    logic [2*SLOT_W-1:0]   h_pkg_reg, h_pkg_next;
    logic                  is_valid_reg;
    logic [1:0]            is_mask_reg;
    logic [2*SLOT_W-1:0]   is_pkg_reg, is_pkg_next;
    logic [REG_NUM-1:0]    busy_reg, busy_next, busy_eff, wb_clr, busy_set;

    logic [NUM_WB-1:0][REG_NUM-1:0] wb_onehot;
    logic [1:0][REG_NUM-1:0]        set_onehot;
    logic [1:0][4:0]                rs0, rs1, wr;
    logic [1:0]                     haz;
    logic [1:0]                     issue_mask;
    logic                           o_free, slot0_haz, iss0, iss1, dep1, all_issue, accept;

    genvar gi;

    generate
        for (gi = 0; gi < NUM_WB; gi++) begin : g_wb
            assign wb_onehot[gi] = wb_valid_i[gi] ? (REG_NUM'(1) << wb_reg_i[gi*5 +: 5]) : '0;
        end
    endgenerate

    always_comb begin
        wb_clr = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            wb_clr = wb_clr | wb_onehot[k];
        end
    end

    // Writebacks landing this cycle already count as free (bypass).
    assign busy_eff = busy_reg & ~wb_clr;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            assign rs0[gi] = h_pkg_reg[gi*SLOT_W +: 5];
            assign rs1[gi] = h_pkg_reg[gi*SLOT_W + 5 +: 5];
            assign wr[gi]  = h_pkg_reg[gi*SLOT_W + 10 +: 5];
            assign haz[gi] = ((rs0[gi] != 5'd0) && busy_eff[rs0[gi]]) ||
                             ((rs1[gi] != 5'd0) && busy_eff[rs1[gi]]) ||
                             ((wr[gi]  != 5'd0) && busy_eff[wr[gi]]);
            assign set_onehot[gi] = (issue_mask[gi] && (wr[gi] != 5'd0)) ? (REG_NUM'(1) << wr[gi]) : '0;
            assign is_pkg_next[gi*SLOT_W +: SLOT_W] = issue_mask[gi] ? h_pkg_reg[gi*SLOT_W +: SLOT_W] : '0;
        end
    endgenerate

    assign o_free    = !is_valid_reg || is_ready_i;
    assign slot0_haz = h_mask_reg[0] ? haz[0] : haz[1];
    assign iss0      = h_valid_reg && o_free && !slot0_haz;
    // Slot 1 may not consume or overwrite the register slot 0 is producing in the same packet.
    assign dep1      = (wr[0] != 5'd0) &&
                       ((rs0[1] == wr[0]) || (rs1[1] == wr[0]) || (wr[1] == wr[0]));
    assign iss1      = iss0 && (h_mask_reg == 2'b11) && !haz[1] && !dep1;

    always_comb begin
        issue_mask = 2'b00;
        case (h_mask_reg)
            2'b11:   issue_mask = {iss1, iss0};
            2'b01:   issue_mask = {1'b0, iss0};
            2'b10:   issue_mask = {iss0, 1'b0};
            default: issue_mask = 2'b00;
        endcase
    end

    assign all_issue   = (issue_mask == h_mask_reg);
    assign pkg_ready_o = !h_valid_reg || all_issue;
    assign accept      = pkg_valid_i && pkg_ready_o;

    always_comb begin
        h_mask_next = h_mask_reg & ~issue_mask;
        h_pkg_next  = h_pkg_reg;
        if (accept) begin
            h_mask_next = pkg_mask_i;
            h_pkg_next  = pkg_i;
        end
        h_valid_next = |h_mask_next;
        busy_set     = set_onehot[0] | set_onehot[1];
        busy_next    = busy_eff | busy_set;
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            h_valid_reg  <= 1'b0;
            h_mask_reg   <= 2'b00;
            is_valid_reg <= 1'b0;
            is_mask_reg  <= 2'b00;
            busy_reg     <= '0;
        end else begin
            h_valid_reg <= h_valid_next;
            h_mask_reg  <= h_mask_next;
            busy_reg    <= busy_next;
            if (o_free) begin
                is_valid_reg <= |issue_mask;
                is_mask_reg  <= issue_mask;
            end
        end
    end

    // Payload registers carry no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        h_pkg_reg <= h_pkg_next;
        if (o_free) begin
            is_pkg_reg <= is_pkg_next;
        end
    end

    assign is_valid_o = is_valid_reg;
    assign is_mask_o  = is_mask_reg;
    assign is_pkg_o   = is_pkg_reg;

`ifdef WIRED_SB_STAT_EN
    logic [31:0] perf_reg;

    // Flush leaves the counter alone; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_reg <= 32'd0;
        end else if (h_valid_reg && o_free && slot0_haz) begin
            perf_reg <= perf_reg + 32'd1;
        end
    end

    assign perf_stall_o = perf_reg;
`else
    assign perf_stall_o = 32'd0;
`endif

endmodule

// File: tb/tb_wired_issue_scoreboard.sv
// Directed bench for wired_issue_scoreboard: expected issue packets go into a queue, a monitor checks handshakes.
module tb_wired_issue_scoreboard;

    localparam int SLOT_W = 32;
`ifdef WIRED_SB_STAT_EN
    localparam logic [31:0] PERF_EXP = 32'd5;
`else
    localparam logic [31:0] PERF_EXP = 32'd0;
`endif

    typedef struct packed {
        logic [1:0]  mask;
        logic [63:0] pkg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush_i, pkg_valid_i, pkg_ready_o, is_valid_o, is_ready_i;
    logic [1:0]  pkg_mask_i, is_mask_o, wb_valid_i;
    logic [63:0] pkg_i, is_pkg_o;
    logic [9:0]  wb_reg_i;
    logic [31:0] perf_stall_o;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] s_a, s_b, s_c, s_d, s_e, s_f, s_g, s_h, s_i, s_j, s_k, s_l, s_m, s_n;

    always #5 clk = ~clk;

    wired_issue_scoreboard #(.NUM_WB(2), .REG_NUM(32), .SLOT_W(SLOT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .pkg_valid_i  (pkg_valid_i),
        .pkg_ready_o  (pkg_ready_o),
        .pkg_mask_i   (pkg_mask_i),
        .pkg_i        (pkg_i),
        .wb_valid_i   (wb_valid_i),
        .wb_reg_i     (wb_reg_i),
        .is_valid_o   (is_valid_o),
        .is_ready_i   (is_ready_i),
        .is_mask_o    (is_mask_o),
        .is_pkg_o     (is_pkg_o),
        .perf_stall_o (perf_stall_o)
    );

    function automatic logic [31:0] mk(input logic [4:0] w, input logic [4:0] r0,
                                       input logic [4:0] r1, input logic [16:0] tag);
        return {tag, w, r1, r0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end else begin
            $display("ok   %s value=%0h", nm, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] m, input logic [31:0] s1, input logic [31:0] s0);
        pkg_valid_i = 1'b1;
        pkg_mask_i  = m;
        pkg_i       = {s1, s0};
    endtask

    task automatic push(input logic [1:0] m, input logic [31:0] s1, input logic [31:0] s0);
        exp_t e;
        e.mask = m;
        e.pkg  = {s1, s0};
        q.push_back(e);
    endtask

    task automatic wb(input logic [1:0] v, input logic [4:0] r1, input logic [4:0] r0);
        wb_valid_i = v;
        wb_reg_i   = {r1, r0};
    endtask

    // Monitor: every accepted issue packet must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && is_valid_o && is_ready_i) begin
            if (q.size() == 0) begin
                chk("mon_unexpected_issue", {62'd0, is_mask_o}, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("mon_mask", {62'd0, is_mask_o}, {62'd0, e.mask});
                chk("mon_pkg", is_pkg_o, e.pkg);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush_i = 1'b0; pkg_valid_i = 1'b0; pkg_mask_i = 2'b00; pkg_i = '0;
        wb_valid_i = 2'b00; wb_reg_i = '0; is_ready_i = 1'b1;
        s_a = mk(4, 5, 6, 1);    s_b = mk(7, 8, 9, 2);
        s_c = mk(4, 1, 2, 3);    s_d = mk(12, 4, 3, 4);
        s_e = mk(4, 0, 0, 5);    s_f = mk(13, 4, 0, 6);
        s_g = mk(14, 0, 0, 7);   s_h = mk(15, 1, 1, 8);   s_i = mk(16, 0, 0, 9);
        s_j = mk(17, 0, 0, 10);  s_k = mk(18, 0, 0, 11);  s_l = mk(14, 17, 18, 12);
        s_m = mk(4, 0, 0, 13);   s_n = mk(19, 4, 0, 14);
        step(); step();
        chk("rst_is_valid", 64'(is_valid_o), 64'd0);
        chk("rst_pkg_ready", 64'(pkg_ready_o), 64'd1);
        chk("rst_perf", 64'(perf_stall_o), 64'd0);
        rst = 1'b0;

        // Dual issue of independent slots
        send(2'b11, s_b, s_a); push(2'b11, s_b, s_a);
        step();
        pkg_valid_i = 1'b0;
        chk("t1_latency", 64'(is_valid_o), 64'd0);
        chk("t1_pkg_ready", 64'(pkg_ready_o), 64'd1);
        step();
        chk("t1_is_valid", 64'(is_valid_o), 64'd1);
        chk("t1_is_mask", 64'(is_mask_o), 64'd3);
        step();
        chk("t1_drain", 64'(is_valid_o), 64'd0);

        // WAW on busy r4, then intra-packet RAW splits the packet
        send(2'b11, s_d, s_c);
        step();
        pkg_valid_i = 1'b0;
        chk("t2_waw_stall", 64'(pkg_ready_o), 64'd0);
        step();
        chk("t2_no_issue", 64'(is_valid_o), 64'd0);
        wb(2'b10, 5'd7, 5'd0);
        step();
        wb(2'b01, 5'd0, 5'd4);
        #1;
        chk("t2_slot1_held", 64'(pkg_ready_o), 64'd0);
        push(2'b01, 32'd0, s_c);
        step();
        wb(2'b00, 5'd0, 5'd0);
        chk("t2_slot0_mask", 64'(is_mask_o), 64'd1);
        step();
        chk("t2_stall_valid", 64'(is_valid_o), 64'd0);
        step();
        chk("t2_stall_ready", 64'(pkg_ready_o), 64'd0);
        wb(2'b01, 5'd0, 5'd4);
        #1;
        chk("t2_wb_release", 64'(pkg_ready_o), 64'd1);
        push(2'b10, s_d, 32'd0);
        step();
        wb(2'b00, 5'd0, 5'd0);
        chk("t2_slot1_mask", 64'(is_mask_o), 64'd2);
        step();

        // Same-cycle writeback bypass
        send(2'b01, 32'd0, s_e); push(2'b01, 32'd0, s_e);
        step();
        pkg_valid_i = 1'b0;
        step();
        send(2'b01, 32'd0, s_f);
        step();
        pkg_valid_i = 1'b0;
        chk("t3_raw_stall", 64'(pkg_ready_o), 64'd0);
        wb(2'b01, 5'd0, 5'd4);
        #1;
        chk("t3_bypass_ready", 64'(pkg_ready_o), 64'd1);
        push(2'b01, 32'd0, s_f);
        step();
        wb(2'b00, 5'd0, 5'd0);
        chk("t3_issued", 64'(is_valid_o), 64'd1);
        step();

        // Backpressure: O holds, next packets wait in order
        is_ready_i = 1'b0;
        send(2'b01, 32'd0, s_g); push(2'b01, 32'd0, s_g);
        step();
        send(2'b01, 32'd0, s_h); push(2'b01, 32'd0, s_h);
        step();
        send(2'b01, 32'd0, s_i); push(2'b01, 32'd0, s_i);
        for (int i = 0; i < 3; i++) begin
            chk("t4_hold_valid", 64'(is_valid_o), 64'd1);
            chk("t4_hold_pkg", is_pkg_o, {32'd0, s_g});
            chk("t4_pkg_ready", 64'(pkg_ready_o), 64'd0);
            step();
        end
        is_ready_i = 1'b1;
        #1;
        chk("t4_release_ready", 64'(pkg_ready_o), 64'd1);
        step();
        pkg_valid_i = 1'b0;
        step();
        step();
        chk("t4_drain", 64'(is_valid_o), 64'd0);

        // Flush with H, O and busy all populated
        is_ready_i = 1'b0;
        send(2'b01, 32'd0, s_j);
        step();
        send(2'b01, 32'd0, s_k);
        step();
        pkg_valid_i = 1'b0;
        chk("t5_pre_valid", 64'(is_valid_o), 64'd1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        is_ready_i = 1'b1;
        chk("t5_flush_valid", 64'(is_valid_o), 64'd0);
        chk("t5_flush_ready", 64'(pkg_ready_o), 64'd1);
        send(2'b01, 32'd0, s_l); push(2'b01, 32'd0, s_l);
        step();
        pkg_valid_i = 1'b0;
        chk("t5_busy_cleared", 64'(pkg_ready_o), 64'd1);
        step();
        chk("t5_issue", 64'(is_valid_o), 64'd1);
        step();

        // Stall counter over a 5-cycle slot0 hazard
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_perf_reset", 64'(perf_stall_o), 64'd0);
        send(2'b01, 32'd0, s_m); push(2'b01, 32'd0, s_m);
        step();
        send(2'b01, 32'd0, s_n); push(2'b01, 32'd0, s_n);
        step();
        pkg_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("t6_perf_stall", 64'(perf_stall_o), 64'(PERF_EXP));
        wb(2'b01, 5'd0, 5'd4);
        step();
        wb(2'b00, 5'd0, 5'd0);
        chk("t6_issue", 64'(is_valid_o), 64'd1);
        step();
        chk("t6_perf_final", 64'(perf_stall_o), 64'(PERF_EXP));
        step();

        chk("sb_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
